// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC configuration sequencer: state encoding,
// bank geometry and the fixed register-write table.
package adc_cfg_pkg;

  localparam int ADC_WORD_W = 24;
  localparam int NUM_ADC    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HWRST,
    ST_RWAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  // Each entry is {8-bit register address, 16-bit register data}.
  function automatic logic [ADC_WORD_W-1:0] cfg_word(input logic [4:0] idx);
    case (idx)
      5'd0:    cfg_word = 24'h000001;
      5'd1:    cfg_word = 24'h011234;
      5'd2:    cfg_word = 24'h02A5C3;
      5'd3:    cfg_word = 24'h03FF00;
      5'd4:    cfg_word = 24'h0400FF;
      5'd5:    cfg_word = 24'h0F8001;
      5'd6:    cfg_word = 24'h105A5A;
      5'd7:    cfg_word = 24'h3E0C0C;
      default: cfg_word = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/adc_cfg_rom.sv
// Combinational lookup of the configuration table; entries past the
// configured word count read as zero.
module adc_cfg_rom
  import adc_cfg_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic [4:0]            index,
  output logic [ADC_WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    if (int'(index) < NUM_WORDS) word = cfg_word(index);
  end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Answers ADC_INIT from the reset manager: pulses the ADC hardware reset,
// serially writes the configuration table to the selected ADCs, then reports done.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int RST_CYC   = 4,
  parameter int RST_WAIT  = 8,
  parameter int NUM_WORDS = 8,
  parameter int GAP       = 4
) (
  input  logic               CLK,
  input  logic               awrst,
  input  logic               ADC_INIT,
  input  logic [NUM_ADC-1:0] CS_MASK,
  output logic               ADC_INIT_DONE,
  output logic               BUSY,
  output logic [4:0]         WORD_CNT,
  output logic               ADC_RESET,
  output logic [NUM_ADC-1:0] ADC_CSB,
  output logic               ADC_SCLK,
  output logic               ADC_SDATA
);

  localparam int CNT_MAX = (RST_CYC > RST_WAIT)
                           ? ((RST_CYC > GAP) ? ((RST_CYC > CLK_DIV) ? RST_CYC : CLK_DIV)
                                              : ((GAP > CLK_DIV) ? GAP : CLK_DIV))
                           : ((RST_WAIT > GAP) ? ((RST_WAIT > CLK_DIV) ? RST_WAIT : CLK_DIV)
                                               : ((GAP > CLK_DIV) ? GAP : CLK_DIV));
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);
  localparam logic [4:0]       LAST_WORD = 5'(NUM_WORDS - 1);
  localparam logic [4:0]       LAST_BIT  = 5'(ADC_WORD_W - 1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;
  logic [4:0]              bit_cnt;
  logic [NUM_ADC-1:0]      mask;
  logic [ADC_WORD_W-1:0]   rom_word;
  logic [ADC_WORD_W-1:0]   shreg;

  adc_cfg_rom #(.NUM_WORDS(NUM_WORDS)) u_rom (
    .index (WORD_CNT),
    .word  (rom_word)
  );

  // shreg holds the bits still to be sent, next bit at the MSB; it is always
  // loaded before use, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (state == ST_LOAD)
      shreg <= {rom_word[ADC_WORD_W-2:0], 1'b0};
    else if (state == ST_SHIFT && cnt == '0 && ADC_SCLK)
      shreg <= shreg << 1;
  end

  always_ff @(posedge CLK or posedge awrst) begin
    if (awrst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      mask          <= '0;
      ADC_INIT_DONE <= 1'b0;
      BUSY          <= 1'b0;
      WORD_CNT      <= '0;
      ADC_RESET     <= 1'b0;
      ADC_CSB       <= '1;
      ADC_SCLK      <= 1'b0;
      ADC_SDATA     <= 1'b0;
    end else if (BUSY && !ADC_INIT) begin
      // Request withdrawn mid-sequence: drop everything, never finish the word.
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      mask          <= '0;
      ADC_INIT_DONE <= 1'b0;
      BUSY          <= 1'b0;
      WORD_CNT      <= '0;
      ADC_RESET     <= 1'b0;
      ADC_CSB       <= '1;
      ADC_SCLK      <= 1'b0;
      ADC_SDATA     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ADC_INIT) begin
            if (CS_MASK != '0) begin
              mask      <= CS_MASK;
              state     <= ST_HWRST;
              ADC_RESET <= 1'b1;
              BUSY      <= 1'b1;
              cnt       <= RST_LD;
            end else begin
              state         <= ST_DONE;
              ADC_INIT_DONE <= 1'b1;
              WORD_CNT      <= 5'(NUM_WORDS);
            end
          end
        end
        ST_HWRST: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state     <= ST_RWAIT;
            ADC_RESET <= 1'b0;
            cnt       <= WAIT_LD;
          end
        end
        ST_RWAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state    <= ST_LOAD;
            WORD_CNT <= '0;
          end
        end
        ST_LOAD: begin
          state     <= ST_SHIFT;
          ADC_CSB   <= ~mask;
          ADC_SCLK  <= 1'b0;
          ADC_SDATA <= rom_word[ADC_WORD_W-1];
          bit_cnt   <= LAST_BIT;
          cnt       <= DIV_LD;
        end
        ST_SHIFT: begin
          // SDATA only moves on the high-to-low SCLK transition.
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!ADC_SCLK) begin
            ADC_SCLK <= 1'b1;
            cnt      <= DIV_LD;
          end else if (bit_cnt == '0) begin
            state     <= ST_GAP;
            ADC_SCLK  <= 1'b0;
            ADC_SDATA <= 1'b0;
            ADC_CSB   <= '1;
            cnt       <= GAP_LD;
          end else begin
            ADC_SCLK  <= 1'b0;
            ADC_SDATA <= shreg[ADC_WORD_W-1];
            bit_cnt   <= bit_cnt - 1'b1;
            cnt       <= DIV_LD;
          end
        end
        ST_GAP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            WORD_CNT <= WORD_CNT + 5'd1;
            if (WORD_CNT == LAST_WORD) begin
              state         <= ST_DONE;
              ADC_INIT_DONE <= 1'b1;
              BUSY          <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (!ADC_INIT) begin
            state         <= ST_IDLE;
            ADC_INIT_DONE <= 1'b0;
            WORD_CNT      <= '0;
            mask          <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer: default build plus a CLK_DIV=1,
// NUM_WORDS=1 build, with a pin monitor that reassembles serial frames.
module tb_adc_cfg_sequencer;

  logic       CLK = 1'b0;
  logic       awrst;
  logic       init [2];
  logic [5:0] mask [2];
  logic       done [2];
  logic       busy [2];
  logic [4:0] wc   [2];
  logic       arst [2];
  logic [5:0] csb  [2];
  logic       sclk [2];
  logic       sdata[2];

  always #5 CLK = ~CLK;

  adc_cfg_sequencer dut0 (
    .CLK(CLK), .awrst(awrst), .ADC_INIT(init[0]), .CS_MASK(mask[0]),
    .ADC_INIT_DONE(done[0]), .BUSY(busy[0]), .WORD_CNT(wc[0]), .ADC_RESET(arst[0]),
    .ADC_CSB(csb[0]), .ADC_SCLK(sclk[0]), .ADC_SDATA(sdata[0])
  );

  adc_cfg_sequencer #(.CLK_DIV(1), .NUM_WORDS(1)) dut1 (
    .CLK(CLK), .awrst(awrst), .ADC_INIT(init[1]), .CS_MASK(mask[1]),
    .ADC_INIT_DONE(done[1]), .BUSY(busy[1]), .WORD_CNT(wc[1]), .ADC_RESET(arst[1]),
    .ADC_CSB(csb[1]), .ADC_SCLK(sclk[1]), .ADC_SDATA(sdata[1])
  );

  logic [23:0] exp_rom [8] = '{24'h000001, 24'h011234, 24'h02A5C3, 24'h03FF00,
                               24'h0400FF, 24'h0F8001, 24'h105A5A, 24'h3E0C0C};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin monitor state, per instance.
  logic [23:0] fr_data [2][64];
  int          fr_edges[2][64];
  int          fr_len  [2][64];
  int          fr_gap  [2][64];
  logic [5:0]  fr_sel  [2][64];
  int          nfr[2], gap_len[2], rst_cyc[2], done_cyc[2], sclk_rise[2];
  int          csb_low_cyc[2], unstable[2], cur_edges[2], cur_len[2], cur_gap[2];
  logic [23:0] cur_data[2];
  logic [5:0]  cur_sel[2];
  logic        in_fr[2], prev_sclk[2], prev_sdata[2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      nfr[u] = 0; gap_len[u] = 0; rst_cyc[u] = 0; done_cyc[u] = 0; sclk_rise[u] = 0;
      csb_low_cyc[u] = 0; unstable[u] = 0; cur_edges[u] = 0; cur_len[u] = 0;
      cur_gap[u] = 0; cur_data[u] = '0; cur_sel[u] = '0; in_fr[u] = 1'b0;
      prev_sclk[u] = 1'b0; prev_sdata[u] = 1'b0;
    end
  end

  task automatic mon(input int u, input logic [5:0] c, input logic s, input logic d,
                     input logic r, input logic dn);
    if (r) rst_cyc[u]++;
    if (dn) done_cyc[u]++;
    if (c != 6'h3F) csb_low_cyc[u]++;
    if (s && !prev_sclk[u]) sclk_rise[u]++;
    if (s && d != prev_sdata[u]) unstable[u]++;
    if (c != 6'h3F) begin
      if (!in_fr[u]) begin
        in_fr[u] = 1'b1; cur_data[u] = '0; cur_edges[u] = 0; cur_len[u] = 0;
        cur_sel[u] = '0; cur_gap[u] = gap_len[u];
      end
      cur_len[u]++;
      cur_sel[u] = cur_sel[u] | ~c;
      if (s && !prev_sclk[u]) begin
        cur_data[u] = {cur_data[u][22:0], d};
        cur_edges[u]++;
      end
    end else begin
      if (in_fr[u]) begin
        in_fr[u] = 1'b0;
        if (nfr[u] < 64) begin
          fr_data[u][nfr[u]]  = cur_data[u];
          fr_edges[u][nfr[u]] = cur_edges[u];
          fr_len[u][nfr[u]]   = cur_len[u];
          fr_gap[u][nfr[u]]   = cur_gap[u];
          fr_sel[u][nfr[u]]   = cur_sel[u];
        end
        nfr[u]++;
        gap_len[u] = 0;
      end
      gap_len[u]++;
    end
    prev_sclk[u] = s;
    prev_sdata[u] = d;
  endtask

  always @(negedge CLK) begin
    mon(0, csb[0], sclk[0], sdata[0], arst[0], done[0]);
    mon(1, csb[1], sclk[1], sdata[1], arst[1], done[1]);
  end

  task automatic chk_idle(input string pfx, input int u);
    chk($sformatf("%s_csb", pfx),   int'(csb[u]),   int'(6'h3F));
    chk($sformatf("%s_sclk", pfx),  int'(sclk[u]),  0);
    chk($sformatf("%s_sdata", pfx), int'(sdata[u]), 0);
    chk($sformatf("%s_rst", pfx),   int'(arst[u]),  0);
    chk($sformatf("%s_done", pfx),  int'(done[u]),  0);
    chk($sformatf("%s_busy", pfx),  int'(busy[u]),  0);
    chk($sformatf("%s_wc", pfx),    int'(wc[u]),    0);
  endtask

  // k counts clock edges after the call; returns first edge showing ADC_RESET and DONE.
  task automatic run_to_done(input int u, input int budget, output int k_rst, output int k_done);
    k_rst = -1;
    k_done = -1;
    for (int k = 1; k <= budget && k_done < 0; k++) begin
      @(posedge CLK); #1;
      if (k_rst < 0 && arst[u]) k_rst = k;
      if (done[u]) k_done = k;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_rst, k_done, fb, rb, db, sb, cb, found;

    // Reset held while the request is already up.
    awrst = 1'b1;
    init[0] = 1'b1; mask[0] = 6'h3F;
    init[1] = 1'b0; mask[1] = 6'h3F;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset", 0);
    chk_idle("reset1", 1);

    // Full default sequence, all ADCs selected.
    fb = nfr[0];
    awrst = 1'b0;
    run_to_done(0, 2000, k_rst, k_done);
    chk("a_done_seen", int'(k_done > 0), 1);
    chk("a_start_hwrst", k_rst, 1);
    chk("a_latency", k_done - k_rst, 820);
    chk("a_rst_cycles", rst_cyc[0], 4);
    chk("a_wc_done", int'(wc[0]), 8);
    chk("a_busy_done", int'(busy[0]), 0);
    chk("a_frames", nfr[0] - fb, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("a_data%0d", k),  int'(fr_data[0][fb+k]), int'(exp_rom[k]));
      chk($sformatf("a_edges%0d", k), fr_edges[0][fb+k], 24);
      chk($sformatf("a_len%0d", k),   fr_len[0][fb+k], 96);
      if (k > 0) chk($sformatf("a_gap%0d", k), int'(fr_gap[0][fb+k] >= 4), 1);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("a_done_held", int'(done[0]), 1);
    init[0] = 1'b0;
    @(posedge CLK); #1;
    chk("a_drop_done", int'(done[0]), 0);
    chk("a_drop_wc", int'(wc[0]), 0);
    repeat (2) @(posedge CLK);
    #1;

    // Partial mask; the mask input changes after the start and must be ignored.
    fb = nfr[0];
    mask[0] = 6'b000101;
    init[0] = 1'b1;
    @(posedge CLK); #1;
    mask[0] = 6'h3F;
    run_to_done(0, 2000, k_rst, k_done);
    chk("b_done_seen", int'(k_done > 0), 1);
    chk("b_frames", nfr[0] - fb, 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("b_sel%0d", k), int'(fr_sel[0][fb+k]), int'(6'b000101));
    chk("b_data0", int'(fr_data[0][fb]), int'(exp_rom[0]));
    chk("b_data7", int'(fr_data[0][fb+7]), int'(exp_rom[7]));
    init[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Abort during the shift of word 3.
    fb = nfr[0];
    db = done_cyc[0];
    init[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 1500 && found == 0; k++) begin
      @(posedge CLK); #1;
      if (wc[0] == 5'd3 && csb[0] != 6'h3F) found = 1;
    end
    chk("c_reach_word3", found, 1);
    repeat (10) @(posedge CLK);
    #1;
    init[0] = 1'b0;
    @(posedge CLK); #1;
    chk_idle("c_abort", 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("c_no_done", done_cyc[0] - db, 0);
    chk("c_frames", nfr[0] - fb, 4);
    chk("c_partial", int'(fr_edges[0][fb+3] < 24), 1);

    // Restart after abort begins again at HWRST with word 0.
    fb = nfr[0];
    rb = rst_cyc[0];
    init[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(posedge CLK); #1;
      if (nfr[0] > fb) found = 1;
    end
    chk("c_restart_frame", found, 1);
    chk("c_restart_data", int'(fr_data[0][fb]), int'(exp_rom[0]));
    chk("c_restart_edges", fr_edges[0][fb], 24);
    chk("c_restart_rst", rst_cyc[0] - rb, 4);
    chk("c_restart_no_done", done_cyc[0] - db, 0);

    // Asynchronous reset in the middle of a frame acts without a clock edge.
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(posedge CLK); #1;
      if (csb[0] != 6'h3F) found = 1;
    end
    chk("c_second_frame", found, 1);
    repeat (20) @(posedge CLK);
    #3;
    awrst = 1'b1;
    #1;
    chk_idle("c_awrst", 0);
    init[0] = 1'b0;
    @(posedge CLK); #1;
    awrst = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_idle("c_idle", 0);

    // Empty mask: immediate done, no pin activity.
    rb = rst_cyc[0];
    sb = sclk_rise[0];
    cb = csb_low_cyc[0];
    mask[0] = 6'h00;
    init[0] = 1'b1;
    @(posedge CLK); #1;
    chk("d_done", int'(done[0]), 1);
    chk("d_wc", int'(wc[0]), 8);
    chk("d_busy", int'(busy[0]), 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("d_no_rst", rst_cyc[0] - rb, 0);
    chk("d_no_sclk", sclk_rise[0] - sb, 0);
    chk("d_no_csb", csb_low_cyc[0] - cb, 0);
    init[0] = 1'b0;
    @(posedge CLK); #1;
    chk("d_drop_done", int'(done[0]), 0);
    chk("d_drop_wc", int'(wc[0]), 0);

    // Fastest serial clock, single word.
    fb = nfr[1];
    init[1] = 1'b1;
    run_to_done(1, 300, k_rst, k_done);
    chk("e_done_seen", int'(k_done > 0), 1);
    chk("e_latency", k_done - k_rst, 65);
    chk("e_frames", nfr[1] - fb, 1);
    chk("e_data", int'(fr_data[1][fb]), int'(exp_rom[0]));
    chk("e_edges", fr_edges[1][fb], 24);
    chk("e_len", fr_len[1][fb], 48);
    chk("e_wc", int'(wc[1]), 1);
    chk("e_sdata_stable1", unstable[1], 0);
    chk("e_sdata_stable0", unstable[0], 0);
    init[1] = 1'b0;
    @(posedge CLK); #1;
    chk("e_drop_done", int'(done[1]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_cfg_sequencer.md
Name: adc_cfg_sequencer

Overview:
Responder side of the ADC initialisation handshake. The reset manager raises ADC_INIT and waits for ADC_INIT_DONE. On ADC_INIT this block does three things in order:
- pulses the hardware reset of the ADC bank;
- serially writes a fixed table of 24-bit configuration words (8-bit address + 16-bit data) to the selected ADCs;
- returns ADC_INIT_DONE.
It sits in the DAQ clock domain, between the reset manager and the ADC serial control pins.

Parameters:
CLK_DIV, 2, CLK cycles per SCLK half-period (≥1)
RST_CYC, 4, CLK cycles ADC_RESET is held high
RST_WAIT, 8, CLK cycles idle after ADC_RESET falls before first write
NUM_WORDS, 8, configuration words sent (1..31)
GAP, 4, CLK cycles CSB held high between words (≥1)

Ports:
CLK  in  1  DAQ clock
awrst  in  1  asynchronous, active-high reset
ADC_INIT  in  1  init request (level) from the reset manager
CS_MASK  in  6  ADC select, sampled in IDLE; bit i=1 selects ADC i
ADC_INIT_DONE  out  1  init complete, held while ADC_INIT stays high
BUSY  out  1  sequence in progress (HWRST..GAP)
WORD_CNT  out  5  index of current word; NUM_WORDS when done
ADC_RESET  out  1  hardware reset to ADCs, active-high
ADC_CSB  out  6  chip selects, active-low
ADC_SCLK  out  1  serial clock
ADC_SDATA  out  1  serial data, MSB first

Behaviour:
- Reset (awrst high, async) and IDLE: ADC_CSB=6'h3F, ADC_SCLK=0, ADC_SDATA=0, ADC_RESET=0, ADC_INIT_DONE=0, BUSY=0, WORD_CNT=0, mask register=0. All outputs are registered.
- States: IDLE, HWRST, RWAIT, LOAD, SHIFT, GAP, DONE.
- IDLE:
  - If ADC_INIT=1 and CS_MASK≠0: latch CS_MASK and go to HWRST.
  - If ADC_INIT=1 and CS_MASK=0: go directly to DONE (no pins toggle, WORD_CNT=NUM_WORDS).
- HWRST: ADC_RESET=1 for exactly RST_CYC cycles, then RWAIT.
- RWAIT: RST_WAIT cycles, then LOAD with WORD_CNT=0.
- LOAD (1 cycle): fetch ROM[WORD_CNT] into a 24-bit shift register.
- SHIFT (exactly 48*CLK_DIV cycles):
  - ADC_CSB = ~mask throughout.
  - Each bit takes 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SDATA changes only while SCLK is low, and is stable for the whole high phase. The ADC samples on the SCLK rising edge.
  - Bit order is 23 down to 0.
  - On exit: SCLK=0, SDATA=0.
- GAP: CSB=6'h3F for GAP cycles, then WORD_CNT increments. If WORD_CNT becomes NUM_WORDS go to DONE, else LOAD.
- DONE: ADC_INIT_DONE=1 and BUSY=0 while ADC_INIT=1. When ADC_INIT=0, go to IDLE next cycle and drop DONE; WORD_CNT returns to 0.
- A new sequence requires ADC_INIT to go low and then high again.
- ADC_INIT=0 in any of HWRST..GAP aborts: next cycle is IDLE with all outputs at reset values. The partial word is never completed and DONE does not assert.
- CS_MASK changes after IDLE are ignored until the next start.
- awrst mid-sequence: all outputs take reset values immediately (async). Restart is from HWRST with word 0.
- Total latency from the first HWRST cycle to DONE: RST_CYC + RST_WAIT + NUM_WORDS*(1 + 48*CLK_DIV + GAP) cycles.
- Counters:
  - One cycle counter, wide enough for max(RST_CYC, RST_WAIT, GAP, CLK_DIV), reloaded on every state entry.
  - One 5-bit bit counter, 0..23.
  - WORD_CNT is 5 bits and never exceeds NUM_WORDS.

Decomposition:
- Package adc_cfg_pkg holds: the state encoding, ADC_WORD_W=24, NUM_ADC=6, and the configuration word table as constants.
- Sub-module adc_cfg_rom: combinational, index[4:0] → word[23:0]. Indices ≥ NUM_WORDS return 24'h000000.

Test Plan:
- awrst=1 while ADC_INIT=1 → CSB=6'h3F, SCLK=0, SDATA=0, ADC_RESET=0, DONE=0, BUSY=0, WORD_CNT=0; after release, sequence starts from HWRST.
- Defaults, CS_MASK=6'h3F, ADC_INIT held high:
  - ADC_RESET high exactly 4 cycles.
  - 8 frames, each with 24 SCLK rising edges; the bits captured on those edges equal ROM[k].
  - CSB high ≥4 cycles between frames.
  - DONE rises 4+8+8*101=820 cycles after the first HWRST cycle.
  - Dropping ADC_INIT clears DONE one cycle later.
- CS_MASK=6'b000101 → only CSB[0] and CSB[2] go low during SHIFT; CSB[5:3,1] stay 1 throughout.
- ADC_INIT dropped mid-SHIFT of word 3 → next cycle: CSB=6'h3F, SCLK=0, BUSY=0, WORD_CNT=0; DONE never asserts. Re-raising ADC_INIT restarts at HWRST and the first frame is ROM[0].
- CS_MASK=6'h00 with ADC_INIT=1 → DONE one cycle later; no ADC_RESET, SCLK or CSB activity; WORD_CNT=8.
- CLK_DIV=1, NUM_WORDS=1 → SHIFT lasts exactly 48 cycles with SCLK toggling every cycle; SDATA is stable on every rising edge.
